// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared types and constants for the Horner polynomial evaluator
package poly_pkg;

  localparam int POLY_DATA_W = 8;

  typedef enum logic [2:0] {
    LOAD_C,
    LOAD_C_WAIT,
    LOAD_X,
    LOAD_X_WAIT,
    EVAL,
    DONE
  } poly_state_t;

  // Index counter width; kept at least one bit so DEGREE==0 still elaborates.
  function automatic int poly_idx_w(input int degree);
    return (degree < 1) ? 1 : $clog2(degree + 1);
  endfunction

endpackage

// File: rtl/poly_mac.sv
// rtl/poly_mac.sv - combinational acc*x+c with full-width intermediate and overflow bit
module poly_mac #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] y_o,
  output logic              ovf_o
);

  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W:0]   sum;

  assign prod  = {{DATA_W{1'b0}}, acc_i} * {{DATA_W{1'b0}}, x_i};
  assign sum   = {1'b0, prod} + {{(DATA_W+1){1'b0}}, c_i};
  assign y_o   = sum[DATA_W-1:0];
  // An oversized product always yields an oversized sum, so one test covers both.
  assign ovf_o = |sum[2*DATA_W:DATA_W];

endmodule

// File: rtl/poly_horner_eval.sv
// rtl/poly_horner_eval.sv - serial-load Horner polynomial evaluator; OVERFLOW_FLAG_EN adds sticky ovf
module poly_horner_eval
  import poly_pkg::*;
#(
  parameter int DATA_W = POLY_DATA_W,
  parameter int DEGREE = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_result,
  output logic              busy,
  output logic              done
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic              ovf
`endif
);

  localparam int IDX_W = poly_idx_w(DEGREE);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DEGREE);

  poly_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] coef_q [DEGREE+1];
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mac_y;
  logic              mac_ovf;

  poly_mac #(.DATA_W(DATA_W)) u_mac (
    .acc_i (acc_q),
    .x_i   (x_q),
    .c_i   (coef_q[idx_q]),
    .y_o   (mac_y),
    .ovf_o (mac_ovf)
  );

`ifdef OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`else
  wire unused_mac_ovf = mac_ovf;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef OVERFLOW_FLAG_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      LOAD_C: if (go) state_d = LOAD_C_WAIT;
      LOAD_C_WAIT: begin
        if (!go) begin
          if (idx_q == '0) begin
            state_d = LOAD_X;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = LOAD_C;
          end
        end
      end
      LOAD_X: begin
        x_d = data_in;
        if (go) state_d = LOAD_X_WAIT;
      end
      LOAD_X_WAIT: begin
        if (!go) begin
          acc_d = coef_q[DEGREE];
`ifdef OVERFLOW_FLAG_EN
          ovf_d = 1'b0;
`endif
          // A constant polynomial has no Horner steps; its value is already in acc.
          if (DEGREE == 0) begin
            state_d = DONE;
          end else begin
            idx_d   = IDX_W'(DEGREE - 1);
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        acc_d = mac_y;
`ifdef OVERFLOW_FLAG_EN
        ovf_d = ovf_q | mac_ovf;
`endif
        if (idx_q == '0) state_d = DONE;
        else             idx_d   = idx_q - 1'b1;
      end
      DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        idx_d    = IDX_TOP;
        state_d  = LOAD_C;
      end
      default: state_d = LOAD_C;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= LOAD_C;
      idx_q    <= IDX_TOP;
      x_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i <= DEGREE; i++) coef_q[i] <= '0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      if (state_q == LOAD_C) coef_q[idx_q] <= data_in;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign data_result = result_q;
  assign done        = done_q;
  assign busy        = (state_q == EVAL) || (state_q == DONE);

endmodule

// File: tb/tb_poly_horner_eval.sv
// tb/tb_poly_horner_eval.sv - randomized self-checking bench for poly_horner_eval (DEGREE 3 and 0)
module tb_poly_horner_eval;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go3 = 1'b0;
  logic       go0 = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] result3, result0;
  logic       busy3, busy0, done3, done0;
`ifdef OVERFLOW_FLAG_EN
  logic       ovf3, ovf0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] coef_m [4];

  always #5 clk = ~clk;

  poly_horner_eval #(.DATA_W(8), .DEGREE(3)) dut3 (
    .clk(clk), .resetn(resetn), .go(go3), .data_in(data_in),
    .data_result(result3), .busy(busy3), .done(done3)
`ifdef OVERFLOW_FLAG_EN
    , .ovf(ovf3)
`endif
  );

  poly_horner_eval #(.DATA_W(8), .DEGREE(0)) dut0 (
    .clk(clk), .resetn(resetn), .go(go0), .data_in(data_in),
    .data_result(result0), .busy(busy0), .done(done0)
`ifdef OVERFLOW_FLAG_EN
    , .ovf(ovf0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // y = sum a[i]*x^i, reduced modulo 256 at the end.
  function automatic logic [7:0] ref_y(input int deg, input logic [7:0] x);
    longint s = 0;
    longint p = 1;
    for (int i = 0; i <= deg; i++) begin
      s += longint'(coef_m[i]) * p;
      p *= longint'(x);
    end
    return 8'(s % 256);
  endfunction

  function automatic logic ref_ovf(input int deg, input logic [7:0] x);
    int acc = coef_m[deg];
    logic o = 1'b0;
    for (int i = deg - 1; i >= 0; i--) begin
      acc = acc * int'(x) + int'(coef_m[i]);
      if (acc > 255) o = 1'b1;
      acc = acc % 256;
    end
    return o;
  endfunction

  task automatic set_go(input int deg, input logic v);
    if (deg == 3) go3 = v;
    else          go0 = v;
  endtask

  task automatic send_value(input int deg, input logic [7:0] v, input int hold);
    data_in = v;
    @(negedge clk);
    set_go(deg, 1'b1);
    repeat (hold) @(negedge clk);
    set_go(deg, 1'b0);
    @(negedge clk);
  endtask

  task automatic load_all(input int deg, input logic [7:0] x, input int hold);
    for (int i = deg; i >= 0; i--) send_value(deg, coef_m[i], hold);
    send_value(deg, x, hold);
  endtask

  task automatic wait_and_check(input string tag, input int deg, input logic [7:0] x);
    int n = 0;
    int bc = 0;
    logic d;
    do begin
      @(negedge clk);
      n++;
      if ((deg == 3) ? busy3 : busy0) bc++;
      d = (deg == 3) ? done3 : done0;
    end while (!d && n < 40);
    check({tag, "_done_seen"}, 32'(d), 32'd1);
    check({tag, "_latency"}, n, deg + 1);
    check({tag, "_busy_cycles"}, bc, deg);
    check({tag, "_result"}, (deg == 3) ? result3 : result0, ref_y(deg, x));
`ifdef OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, (deg == 3) ? ovf3 : ovf0, ref_ovf(deg, x));
`endif
    @(negedge clk);
    check({tag, "_done_single"}, (deg == 3) ? done3 : done0, 32'd0);
  endtask

  task automatic run_eval(input string tag, input int deg, input logic [7:0] x, input int hold);
    load_all(deg, x, hold);
    wait_and_check(tag, deg, x);
  endtask

  initial begin
    logic [7:0] first;
    logic [7:0] xr;
    repeat (3) @(negedge clk);
    check("rst_result3", result3, 0);
    check("rst_busy3", busy3, 0);
    check("rst_done3", done3, 0);
    check("rst_result0", result0, 0);
    resetn = 1'b1;
    @(negedge clk);

    coef_m = '{8'd4, 8'd3, 8'd2, 8'd1};
    run_eval("T1", 3, 8'd2, 1);
    check("T1_const", result3, 26);

    coef_m = '{8'd0, 8'd0, 8'd0, 8'd1};
    run_eval("T2", 3, 8'd8, 1);

    coef_m = '{8'd4, 8'd3, 8'd2, 8'd1};
    run_eval("T3", 3, 8'd2, 20);

    load_all(3, 8'd2, 1);
    @(negedge clk);
    check("T4_busy_before", busy3, 1);
    resetn = 1'b0;
    #1;
    check("T4_result", result3, 0);
    check("T4_busy", busy3, 0);
    check("T4_done", done3, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    coef_m = '{8'd7, 8'd0, 8'd5, 8'd3};
    run_eval("T4_reload", 3, 8'd3, 2);

    coef_m[0] = 8'h5A;
    run_eval("T5", 0, 8'h33, 1);

    coef_m = '{8'd9, 8'd1, 8'd1, 8'd2};
    run_eval("T6a", 3, 8'd5, 1);
    first = result3;
    coef_m = '{8'd1, 8'd1, 8'd1, 8'd1};
    load_all(3, 8'd4, 2);
    check("T6_hold", result3, first);
    wait_and_check("T6b", 3, 8'd4);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) coef_m[i] = 8'($urandom);
      xr = 8'($urandom);
      run_eval($sformatf("R3_%0d", k), 3, xr, int'($urandom_range(1, 3)));
    end
    for (int k = 0; k < 3; k++) begin
      coef_m[0] = 8'($urandom);
      xr = 8'($urandom);
      run_eval($sformatf("R0_%0d", k), 0, xr, int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
